// File: rtl/addr_bus_pkg.sv
// Shared definitions for the addressable peripheral bus: FSM state codes,
// transfer direction, and a helper sizing the internal down-counters.
package addr_bus_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_STROBE = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_HOLD   = 3'd4;
   localparam logic [2:0] ST_RESP   = 3'd5;

   typedef enum logic {
      DIR_READ  = 1'b0,
      DIR_WRITE = 1'b1
   } dir_e;

   // Bits needed to hold max_value, never less than one.
   function automatic int count_width(input int max_value);
      int w;
      w = $clog2(max_value + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/addr_bus_if.sv
// Client command/response channels plus the peripheral bus pins of the initiator.
// master is the initiator's view; slave is the client/responder side.
interface addr_bus_if #(
   parameter int width         = 8,
   parameter int address_width = 4
);

   logic                     cmd_valid;
   logic                     cmd_ready;
   logic                     cmd_write;
   logic [address_width-1:0] cmd_address;
   logic [width-1:0]         cmd_data;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [width-1:0]         rsp_data;
   logic                     busy;
   logic [address_width-1:0] active_address;
   logic                     write_enable;
   logic                     read_enable;
   logic [width-1:0]         bus_data_out;
   logic [width-1:0]         bus_data_in;

   modport master (
      input  cmd_valid, cmd_write, cmd_address, cmd_data, rsp_ready, bus_data_in,
      output cmd_ready, rsp_valid, rsp_data, busy,
             active_address, write_enable, read_enable, bus_data_out
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_address, cmd_data, rsp_ready, bus_data_in,
      input  cmd_ready, rsp_valid, rsp_data, busy,
             active_address, write_enable, read_enable, bus_data_out
   );

endinterface

// File: rtl/addr_bus_initiator_cycle_counter.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module cycle_counter #(
   parameter int width = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [width-1:0] load_value,
   input  logic             decrement,
   output logic             zero
);

   logic [width-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (decrement && (count != '0)) begin
         count <= count - width'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/addr_bus_initiator.sv
// Bus initiator: takes one client command at a time and plays it onto the
// peripheral bus as setup / strobe / hold-or-wait, returning read data on rsp_*.
module addr_bus_initiator
   import addr_bus_pkg::*;
#(
   parameter int width         = 8,
   parameter int address_width = 4,
   parameter int idle_address  = 0,
   parameter int read_latency  = 1,
   parameter int gap_cycles    = 2
) (
   input logic         clock,
   input logic         reset,
   addr_bus_if.master  bus
);

   localparam int gap_w = count_width(gap_cycles);
   localparam int lat_w = count_width(read_latency);
   localparam logic [address_width-1:0] idle_addr = address_width'(idle_address);

   logic [2:0] state;
   dir_e       dir;
   logic       gap_zero;
   logic       gap_load;
   logic       lat_zero;
   logic       lat_load;
   logic       lat_dec;

   assign bus.cmd_ready = (state == ST_IDLE) && gap_zero;
   assign bus.busy      = (state != ST_IDLE) || !gap_zero;

   // Every return to IDLE restarts the inter-transaction gap.
   assign gap_load = (state == ST_HOLD) || ((state == ST_RESP) && bus.rsp_ready);

   // Loaded during SETUP and already counting through STROBE, so WAIT ends
   // on the cycle the count sits at zero: read_latency cycles after the strobe.
   assign lat_load = (state == ST_SETUP);
   assign lat_dec  = (state == ST_STROBE) || (state == ST_WAIT);

   cycle_counter #(.width(gap_w)) gap_counter (
      .clock      (clock),
      .reset      (reset),
      .load       (gap_load),
      .load_value (gap_w'(gap_cycles)),
      .decrement  (1'b1),
      .zero       (gap_zero)
   );

   cycle_counter #(.width(lat_w)) latency_counter (
      .clock      (clock),
      .reset      (reset),
      .load       (lat_load),
      .load_value (lat_w'(read_latency)),
      .decrement  (lat_dec),
      .zero       (lat_zero)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state              <= ST_IDLE;
         dir                <= DIR_READ;
         bus.active_address <= idle_addr;
         bus.bus_data_out   <= {width{1'b0}};
         bus.write_enable   <= 1'b0;
         bus.read_enable    <= 1'b0;
         bus.rsp_valid      <= 1'b0;
         bus.rsp_data       <= {width{1'b0}};
      end else begin
         bus.write_enable <= 1'b0;
         bus.read_enable  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid && bus.cmd_ready) begin
                  dir                <= dir_e'(bus.cmd_write);
                  bus.active_address <= bus.cmd_address;
                  bus.bus_data_out   <= bus.cmd_data;
                  state              <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               bus.write_enable <= (dir == DIR_WRITE);
               bus.read_enable  <= (dir == DIR_READ);
               state            <= ST_STROBE;
            end
            ST_STROBE: begin
               state <= (dir == DIR_WRITE) ? ST_HOLD : ST_WAIT;
            end
            ST_WAIT: begin
               if (lat_zero) begin
                  bus.rsp_data       <= bus.bus_data_in;
                  bus.rsp_valid      <= 1'b1;
                  bus.active_address <= idle_addr;
                  state              <= ST_RESP;
               end
            end
            ST_HOLD: begin
               bus.active_address <= idle_addr;
               state              <= ST_IDLE;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: begin
               bus.active_address <= idle_addr;
               state              <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addr_bus_initiator.sv
// Self-checking bench for addr_bus_initiator: directed vector table, hand-written
// gap/reset sequences and a random command stream against a memory model.
module tb_addr_bus_initiator;

   localparam int W   = 8;
   localparam int AW  = 4;
   localparam int RL  = 1;
   localparam int GAP = 2;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
      logic [W-1:0]  expData;
      int            hold;
   } vec_t;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   addr_bus_if #(.width(W), .address_width(AW)) bus ();

   addr_bus_initiator #(
      .width         (W),
      .address_width (AW),
      .idle_address  (0),
      .read_latency  (RL),
      .gap_cycles    (GAP)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int       passCount = 0;
   int       checkCount = 0;
   int       cyc = 0;
   int       strobeCount = 0;
   int       overlapCount = 0;
   int       strobeTimes[$];
   logic [W-1:0] respMem[16];
   logic [W-1:0] refMem[16];

   // Responder with one cycle of read latency, plus a strobe monitor.
   always @(posedge clock) begin
      cyc++;
      if (bus.write_enable || bus.read_enable) begin
         strobeCount++;
         strobeTimes.push_back(cyc);
      end
      if (bus.write_enable && bus.read_enable) overlapCount++;
      if (bus.write_enable) respMem[bus.active_address] = bus.bus_data_out;
      if (bus.read_enable) bus.bus_data_in <= respMem[bus.active_address];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic waitReady();
      int n = 0;
      while (!bus.cmd_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      checkOutput("cmd_ready before accept", 32'(bus.cmd_ready), 32'd1);
   endtask

   // Full transaction with cycle-by-cycle checks; called at a falling edge.
   task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] data,
                                input logic [W-1:0] expData, input int hold);
      bus.cmd_valid   = 1'b1;
      bus.cmd_write   = wr;
      bus.cmd_address = addr;
      bus.cmd_data    = data;
      waitReady();
      if (!bus.cmd_ready) begin
         bus.cmd_valid = 1'b0;
         return;
      end
      @(negedge clock);
      bus.cmd_valid   = 1'b0;
      bus.cmd_write   = ~wr;
      bus.cmd_address = AW'($urandom);
      bus.cmd_data    = W'($urandom);
      checkOutput("setup address", 32'(bus.active_address), 32'(addr));
      checkOutput("setup enables", 32'({bus.write_enable, bus.read_enable}), 32'd0);
      if (wr) checkOutput("setup data", 32'(bus.bus_data_out), 32'(data));
      @(negedge clock);
      checkOutput("strobe write_enable", 32'(bus.write_enable), 32'(wr));
      checkOutput("strobe read_enable", 32'(bus.read_enable), 32'(!wr));
      checkOutput("strobe address", 32'(bus.active_address), 32'(addr));
      if (wr) begin
         checkOutput("strobe data", 32'(bus.bus_data_out), 32'(data));
         @(negedge clock);
         checkOutput("hold enables", 32'({bus.write_enable, bus.read_enable}), 32'd0);
         checkOutput("hold address", 32'(bus.active_address), 32'(addr));
         checkOutput("hold data", 32'(bus.bus_data_out), 32'(data));
         @(negedge clock);
         checkOutput("post-write address", 32'(bus.active_address), 32'd0);
         checkOutput("post-write cmd_ready in gap", 32'(bus.cmd_ready), 32'd0);
         checkOutput("post-write busy in gap", 32'(bus.busy), 32'd1);
         checkOutput("write gives no rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end else begin
         repeat (RL) begin
            @(negedge clock);
            checkOutput("wait enables", 32'({bus.write_enable, bus.read_enable}), 32'd0);
            checkOutput("wait address", 32'(bus.active_address), 32'(addr));
            checkOutput("wait rsp_valid", 32'(bus.rsp_valid), 32'd0);
         end
         @(negedge clock);
         checkOutput("resp rsp_valid", 32'(bus.rsp_valid), 32'd1);
         checkOutput("resp rsp_data", 32'(bus.rsp_data), 32'(expData));
         checkOutput("resp address idle", 32'(bus.active_address), 32'd0);
         checkOutput("resp cmd_ready", 32'(bus.cmd_ready), 32'd0);
         for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            checkOutput("held rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("held rsp_data", 32'(bus.rsp_data), 32'(expData));
            checkOutput("held cmd_ready", 32'(bus.cmd_ready), 32'd0);
         end
         bus.rsp_ready = 1'b1;
         @(negedge clock);
         bus.rsp_ready = 1'b0;
         checkOutput("rsp_valid after take", 32'(bus.rsp_valid), 32'd0);
         checkOutput("busy in gap after read", 32'(bus.busy), 32'd1);
         checkOutput("cmd_ready in gap after read", 32'(bus.cmd_ready), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t vecs[8];
      int   lowCount;
      int   n;
      int   rises;
      int   diff;
      logic wr;
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
      int   hold;

      for (int i = 0; i < 16; i++) begin
         respMem[i] = W'(8'h10 + i);
         refMem[i]  = W'(8'h10 + i);
      end
      reset = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_write   = 1'b0;
      bus.cmd_address = '0;
      bus.cmd_data    = '0;
      bus.rsp_ready   = 1'b0;

      // Reset state
      repeat (3) @(negedge clock);
      checkOutput("reset enables", 32'({bus.write_enable, bus.read_enable}), 32'd0);
      checkOutput("reset address", 32'(bus.active_address), 32'd0);
      checkOutput("reset bus_data_out", 32'(bus.bus_data_out), 32'd0);
      checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset rsp_data", 32'(bus.rsp_data), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("idle cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("idle busy", 32'(bus.busy), 32'd0);
      checkOutput("idle enables", 32'({bus.write_enable, bus.read_enable}), 32'd0);
      checkOutput("idle address", 32'(bus.active_address), 32'd0);

      // Directed vectors
      vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'h00, 0};
      vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5, 0};
      vecs[2] = '{1'b1, 4'd15, 8'h5A, 8'h00, 0};
      vecs[3] = '{1'b0, 4'd15, 8'h00, 8'h5A, 2};
      vecs[4] = '{1'b0, 4'd7,  8'h00, 8'h17, 0};
      vecs[5] = '{1'b1, 4'd7,  8'hC3, 8'h00, 0};
      vecs[6] = '{1'b0, 4'd7,  8'h00, 8'hC3, 1};
      vecs[7] = '{1'b0, 4'd0,  8'h00, 8'h10, 0};
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].expData, vecs[i].hold);
         if (vecs[i].wr) refMem[vecs[i].addr] = vecs[i].data;
      end

      // Read with a stalled client
      respMem[5] = 8'h3C;
      refMem[5]  = 8'h3C;
      applyStimulus(1'b0, 4'd5, 8'h00, 8'h3C, 5);

      // Two writes offered back to back
      strobeTimes.delete();
      lowCount = 0;
      n = 0;
      bus.cmd_valid   = 1'b1;
      bus.cmd_write   = 1'b1;
      bus.cmd_address = 4'd1;
      bus.cmd_data    = 8'h11;
      waitReady();
      @(negedge clock);
      bus.cmd_address = 4'd2;
      bus.cmd_data    = 8'h22;
      while (n < 20) begin
         if (bus.cmd_ready) break;
         lowCount++;
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      repeat (6) @(negedge clock);
      refMem[1] = 8'h11;
      refMem[2] = 8'h22;
      diff = (strobeTimes.size() >= 2) ? (strobeTimes[1] - strobeTimes[0]) : -1;
      checkOutput("back-to-back cmd_ready low cycles", 32'(lowCount), 32'd5);
      checkOutput("back-to-back strobe count", 32'(strobeTimes.size()), 32'd2);
      checkOutput("back-to-back strobe spacing", 32'(diff), 32'd6);
      applyStimulus(1'b0, 4'd1, 8'h00, 8'h11, 0);
      applyStimulus(1'b0, 4'd2, 8'h00, 8'h22, 0);

      // Reset during a read strobe
      bus.cmd_valid   = 1'b1;
      bus.cmd_write   = 1'b0;
      bus.cmd_address = 4'd9;
      waitReady();
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      @(negedge clock);
      checkOutput("abort strobe present", 32'(bus.read_enable), 32'd1);
      #1 reset = 1'b1;
      #1;
      checkOutput("abort read_enable drops", 32'(bus.read_enable), 32'd0);
      checkOutput("abort address idle", 32'(bus.active_address), 32'd0);
      checkOutput("abort cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("abort busy", 32'(bus.busy), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      rises = 0;
      repeat (6) begin
         @(negedge clock);
         if (bus.rsp_valid) rises++;
      end
      checkOutput("abort rsp_valid never rises", 32'(rises), 32'd0);
      applyStimulus(1'b0, 4'd9, 8'h00, refMem[9], 0);

      // Random stream against the reference memory
      strobeCount = 0;
      for (int i = 0; i < 200; i++) begin
         wr   = 1'($urandom_range(0, 1));
         addr = AW'($urandom);
         data = W'($urandom);
         hold = int'($urandom_range(0, 3));
         applyStimulus(wr, addr, data, refMem[addr], hold);
         if (wr) refMem[addr] = data;
      end
      @(negedge clock);
      checkOutput("random strobe count", 32'(strobeCount), 32'd200);
      checkOutput("enables never overlap", 32'(overlapCount), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
